// File: rtl/wb_unit_if.sv
// Writeback request / memory-response / register-file bus for wb_unit.
// The slave modport is the wb_unit side; master is the pipeline/testbench side.
interface wb_unit_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] alu_result;
    logic [31:0] pc;
    logic [1:0]  wb_src;
    logic [4:0]  rd_addr;
    logic        reg_write;
    logic [2:0]  load_funct3;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        busy;

    modport slave (
        input  in_valid, alu_result, pc, wb_src, rd_addr, reg_write,
               load_funct3, mem_rdata, mem_ack,
        output in_ready, rf_we, rf_waddr, rf_wdata, busy
    );

    modport master (
        output in_valid, alu_result, pc, wb_src, rd_addr, reg_write,
               load_funct3, mem_rdata, mem_ack,
        input  in_ready, rf_we, rf_waddr, rf_wdata, busy
    );
endinterface

// File: rtl/wb_unit.sv
// Writeback stage: selects ALU / load / link result, formats loads and
// drives a registered register-file write port, one request in flight.
module wb_unit (
    input  logic     clk,
    input  logic     rst_n,
    wb_unit_if.slave bus
);
    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] WAIT_MEM = 2'd1;
    localparam logic [1:0] WRITE    = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [1:0]  addr_q, addr_d;
    logic [4:0]  rd_q, rd_d;
    logic        regw_q, regw_d;
    logic [2:0]  f3_q, f3_d;
    logic        we_q, we_d;
    logic [4:0]  waddr_q, waddr_d;
    logic [31:0] wdata_q, wdata_d;

    // Byte lane selected by the low address bits, half-word lane by bit 1.
    function automatic logic [31:0] fmt_load(input logic [31:0] w,
                                             input logic [1:0]  a,
                                             input logic [2:0]  f3);
        logic signed [7:0]  sb;
        logic signed [15:0] sh;
        sb = w[{a, 3'b000} +: 8];
        sh = a[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  fmt_load = 32'(sb);
            3'b100:  fmt_load = {24'd0, sb};
            3'b001:  fmt_load = 32'(sh);
            3'b101:  fmt_load = {16'd0, sh};
            default: fmt_load = w;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rd_d    = rd_q;
        regw_d  = regw_q;
        f3_d    = f3_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    addr_d = bus.alu_result[1:0];
                    rd_d   = bus.rd_addr;
                    regw_d = bus.reg_write;
                    f3_d   = bus.load_funct3;
                    if (bus.wb_src == 2'b01) begin
                        state_d = WAIT_MEM;
                    end else begin
                        // Non-load result is formed at the accepting edge.
                        state_d = WRITE;
                        we_d    = bus.reg_write && (bus.rd_addr != 5'd0);
                        waddr_d = bus.rd_addr;
                        wdata_d = (bus.wb_src == 2'b10) ? bus.pc + 32'd4
                                                        : bus.alu_result;
                    end
                end
            end
            WAIT_MEM: begin
                if (bus.mem_ack) begin
                    state_d = WRITE;
                    we_d    = regw_q && (rd_q != 5'd0);
                    waddr_d = rd_q;
                    wdata_d = fmt_load(bus.mem_rdata, addr_q, f3_q);
                end
            end
            WRITE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= 2'd0;
            rd_q    <= 5'd0;
            regw_q  <= 1'b0;
            f3_q    <= 3'd0;
            we_q    <= 1'b0;
            waddr_q <= 5'd0;
            wdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rd_q    <= rd_d;
            regw_q  <= regw_d;
            f3_q    <= f3_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign bus.in_ready = (state_q == IDLE);
    assign bus.busy     = (state_q != IDLE);
    assign bus.rf_we    = we_q;
    assign bus.rf_waddr = waddr_q;
    assign bus.rf_wdata = wdata_q;
endmodule

// File: tb/tb_wb_unit.sv
// Directed bench for wb_unit: stimulus pushes expected writes into a queue,
// a negedge monitor pops and compares whenever rf_we is seen.
module tb_wb_unit;
    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   failures;

    typedef struct {
        int          cyc;
        logic [4:0]  a;
        logic [31:0] d;
    } exp_t;
    exp_t sb[$];

    logic [4:0]  last_a;
    logic [31:0] last_d;

    wb_unit_if bus ();

    wb_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (rst_n) begin
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                checks++;
                failures++;
                $display("FAIL missing_write actual=none required=x%0d<=%h at cycle %0d",
                         sb[0].a, sb[0].d, sb[0].cyc);
                void'(sb.pop_front());
            end
            if (bus.rf_we === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write actual=x%0d<=%h required=no write",
                             bus.rf_waddr, bus.rf_wdata);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("write_cycle", 32'(cyc), 32'(e.cyc));
                    chk("rf_waddr", 32'(bus.rf_waddr), 32'(e.a));
                    chk("rf_wdata", bus.rf_wdata, e.d);
                end
            end
        end
    end

    task automatic wait_ready();
        int n;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (bus.in_ready !== 1'b1) chk("in_ready_timeout", 32'(bus.in_ready), 32'd1);
    endtask

    task automatic scramble();
        bus.alu_result  = $urandom;
        bus.pc          = $urandom;
        bus.wb_src      = 2'($urandom);
        bus.rd_addr     = 5'($urandom);
        bus.reg_write   = 1'($urandom);
        bus.load_funct3 = 3'($urandom);
    endtask

    // One request; loads get an ack after dly idle cycles in WAIT_MEM.
    task automatic do_req(input logic [1:0] src, input logic [31:0] alu,
                          input logic [31:0] pcv, input logic [4:0] rd,
                          input logic rw, input logic [2:0] f3, input int dly,
                          input logic [31:0] mdata, input logic early_ack,
                          input logic [31:0] expd);
        int   acc;
        int   expc;
        exp_t e;
        wait_ready();
        bus.in_valid    = 1'b1;
        bus.wb_src      = src;
        bus.alu_result  = alu;
        bus.pc          = pcv;
        bus.rd_addr     = rd;
        bus.reg_write   = rw;
        bus.load_funct3 = f3;
        bus.mem_ack     = early_ack;
        bus.mem_rdata   = 32'h1111_1111;
        acc  = cyc + 1;
        expc = (src == 2'b01) ? acc + dly + 1 : acc;
        if (rw && rd != 5'd0) begin
            e.cyc = expc;
            e.a   = rd;
            e.d   = expd;
            sb.push_back(e);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.mem_ack  = 1'b0;
        scramble();
        chk("busy_after_accept", 32'(bus.busy), 32'd1);
        chk("in_ready_after_accept", 32'(bus.in_ready), 32'd0);
        if (src == 2'b01) begin
            chk("hold_waddr", 32'(bus.rf_waddr), 32'(last_a));
            chk("hold_wdata", bus.rf_wdata, last_d);
            repeat (dly) @(negedge clk);
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = mdata;
            @(negedge clk);
            bus.mem_ack   = 1'b0;
            bus.mem_rdata = $urandom;
            chk("in_ready_in_write", 32'(bus.in_ready), 32'd0);
        end
        @(negedge clk);
        chk("busy_back_idle", 32'(bus.busy), 32'd0);
        chk("in_ready_back_idle", 32'(bus.in_ready), 32'd1);
        last_a = rd;
        last_d = expd;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks   = 0;
        failures = 0;
        last_a   = 5'd0;
        last_d   = 32'd0;
        rst_n    = 1'b0;
        bus.in_valid  = 1'b0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'd0;
        scramble();
        #3;
        chk("reset_rf_we", 32'(bus.rf_we), 32'd0);
        chk("reset_rf_waddr", 32'(bus.rf_waddr), 32'd0);
        chk("reset_rf_wdata", bus.rf_wdata, 32'd0);
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // ALU / link paths; the first one is accepted on the first edge after reset
        do_req(2'b00, 32'h1234_5678, 32'h0, 5'd5, 1'b1, 3'd0, 0, 32'h0, 1'b0, 32'h1234_5678);
        do_req(2'b10, 32'h0, 32'hFFFF_FFFC, 5'd1, 1'b1, 3'd0, 0, 32'h0, 1'b0, 32'h0000_0000);
        do_req(2'b10, 32'h0, 32'h0000_1000, 5'd2, 1'b1, 3'd0, 0, 32'h0, 1'b1, 32'h0000_1004);
        do_req(2'b11, 32'hCAFE_F00D, 32'h0, 5'd31, 1'b1, 3'd0, 0, 32'h0, 1'b0, 32'hCAFE_F00D);

        // Loads, 3 idle cycles before ack; early acks must be ignored
        do_req(2'b01, 32'h0000_0103, 32'h0, 5'd3, 1'b1, 3'b000, 3, 32'h80F0_FF7F, 1'b1, 32'hFFFF_FF80);
        do_req(2'b01, 32'h0000_0200, 32'h0, 5'd4, 1'b1, 3'b100, 3, 32'h80F0_FF7F, 1'b0, 32'h0000_007F);
        do_req(2'b01, 32'h0000_0002, 32'h0, 5'd6, 1'b1, 3'b001, 3, 32'h80F0_FF7F, 1'b1, 32'hFFFF_80F0);
        do_req(2'b01, 32'h0000_0002, 32'h0, 5'd8, 1'b1, 3'b101, 3, 32'h80F0_FF7F, 1'b0, 32'h0000_80F0);
        do_req(2'b01, 32'h0000_0000, 32'h0, 5'd9, 1'b1, 3'b010, 3, 32'h80F0_FF7F, 1'b0, 32'h80F0_FF7F);
        do_req(2'b01, 32'h0000_0001, 32'h0, 5'd12, 1'b1, 3'b000, 1, 32'h80F0_FF7F, 1'b0, 32'hFFFF_FFFF);
        do_req(2'b01, 32'h0000_0000, 32'h0, 5'd13, 1'b1, 3'b001, 0, 32'h80F0_FF7F, 1'b0, 32'hFFFF_FF7F);
        do_req(2'b01, 32'h0000_0003, 32'h0, 5'd14, 1'b1, 3'b111, 2, 32'h80F0_FF7F, 1'b0, 32'h80F0_FF7F);
        do_req(2'b01, 32'h0000_0002, 32'h0, 5'd15, 1'b1, 3'b100, 0, 32'h80F0_FF7F, 1'b0, 32'h0000_00F0);
        do_req(2'b01, 32'h0000_0002, 32'h0, 5'd16, 1'b1, 3'b000, 5, 32'h80F0_FF7F, 1'b0, 32'hFFFF_FFF0);

        // x0 and reg_write=0: no write, FSM still returns to IDLE
        do_req(2'b00, 32'h0000_0055, 32'h0, 5'd0, 1'b1, 3'd0, 0, 32'h0, 1'b0, 32'h0000_0055);
        do_req(2'b00, 32'h0000_0066, 32'h0, 5'd7, 1'b0, 3'd0, 0, 32'h0, 1'b0, 32'h0000_0066);
        do_req(2'b01, 32'h0000_0000, 32'h0, 5'd0, 1'b1, 3'b010, 2, 32'hABCD_0123, 1'b0, 32'hABCD_0123);

        // Reset during WAIT_MEM aborts the load
        wait_ready();
        bus.in_valid = 1'b1;
        bus.wb_src = 2'b01; bus.alu_result = 32'h0; bus.rd_addr = 5'd10;
        bus.reg_write = 1'b1; bus.load_funct3 = 3'b010;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("busy_wait_mem", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_reset_busy", 32'(bus.busy), 32'd0);
        chk("async_reset_in_ready", 32'(bus.in_ready), 32'd1);
        chk("async_reset_rf_waddr", 32'(bus.rf_waddr), 32'd0);
        chk("async_reset_rf_wdata", bus.rf_wdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        last_a = 5'd0;
        last_d = 32'd0;
        @(negedge clk);
        bus.mem_ack = 1'b1;
        bus.mem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        @(negedge clk);
        chk("post_reset_busy", 32'(bus.busy), 32'd0);
        chk("post_reset_in_ready", 32'(bus.in_ready), 32'd1);
        chk("post_reset_rf_wdata", bus.rf_wdata, 32'd0);

        // Back-to-back: in_valid held high, one acceptance every second edge
        begin
            int a0;
            exp_t e;
            wait_ready();
            a0 = cyc + 1;
            bus.in_valid = 1'b1;
            for (int i = 0; i < 4; i++) begin
                bus.wb_src = 2'b00;
                bus.alu_result = 32'h1000_0000 + 32'(i) * 32'h11;
                bus.rd_addr = 5'(20 + i);
                bus.reg_write = 1'b1;
                e.cyc = a0 + 2 * i;
                e.a = 5'(20 + i);
                e.d = 32'h1000_0000 + 32'(i) * 32'h11;
                sb.push_back(e);
                @(negedge clk);
                chk("b2b_in_ready_write", 32'(bus.in_ready), 32'd0);
                @(negedge clk);
                chk("b2b_in_ready_idle", 32'(bus.in_ready), 32'd1);
            end
            bus.in_valid = 1'b0;
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
